// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer (title, load, countdown, play, win, lose) with level, lives and timers.
// Define GAME_PAUSE_EN to add a 'P'-key pause state during play.
module game_round_ctrl #(
  parameter int LEVELS           = 4,
  parameter int LIVES            = 3,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int PLAY_FRAMES      = 3600
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   frame_tick,
  input  logic [15:0]                            keycode,
  input  logic                                   goal_reached,
  input  logic                                   hazard_hit,
  output logic [3:0]                             status,
  output logic                                   play_en,
  output logic                                   load_level,
  output logic                                   paused,
  output logic [$clog2(LEVELS)-1:0]              level,
  output logic [$clog2(LIVES+1)-1:0]             lives,
  output logic [$clog2(PLAY_FRAMES+1)-1:0]       time_left,
  output logic [$clog2(COUNTDOWN_FRAMES+1)-1:0]  countdown
);
  localparam int LW  = $clog2(LEVELS);
  localparam int LVW = $clog2(LIVES+1);
  localparam int TW  = $clog2(PLAY_FRAMES+1);
  localparam int CW  = $clog2(COUNTDOWN_FRAMES+1);
  localparam logic [2:0] TITLE = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] COUNT = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] WIN   = 3'd4;
  localparam logic [2:0] LOSE  = 3'd5;
  logic [2:0] state;
  logic enter_now, enter_prev, enter_press, death;
  assign enter_now   = (keycode[15:8] == 8'h28) | (keycode[7:0] == 8'h28);
  assign enter_press = enter_now & ~enter_prev;
  assign death       = hazard_hit | (frame_tick & (time_left == TW'(1)));
`ifdef GAME_PAUSE_EN
  localparam logic [2:0] PAUSE = 3'd6;
  logic p_now, p_prev, p_press;
  assign p_now   = (keycode[15:8] == 8'h13) | (keycode[7:0] == 8'h13);
  assign p_press = p_now & ~p_prev;
  assign paused  = state == PAUSE;
  always_ff @(posedge Clk) p_prev <= Reset | p_now;
`else
  assign paused = 1'b0;
`endif
  assign play_en    = state == PLAY;
  assign load_level = state == LOAD;
  always_comb
    status = state == TITLE ? 4'b0001 :
             state == WIN   ? 4'b0100 :
             state == LOSE  ? 4'b1000 : 4'b0010;
  // prev resets to 1 so an Enter held through reset is not seen as a press
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= TITLE;
      enter_prev <= 1'b1;
      level      <= '0;
      lives      <= '0;
      time_left  <= '0;
      countdown  <= '0;
    end else begin
      enter_prev <= enter_now;
      case (state)
        TITLE: if (enter_press) begin
          level <= '0;
          lives <= LVW'(LIVES);
          state <= LOAD;
        end
        LOAD: begin
          time_left <= TW'(PLAY_FRAMES);
          countdown <= CW'(COUNTDOWN_FRAMES);
          state     <= COUNT;
        end
        COUNT: if (frame_tick) begin
          countdown <= countdown - 1'b1;
          if (countdown == CW'(1)) state <= PLAY;
        end
        PLAY: if (death) begin
          lives <= lives - 1'b1;
          state <= lives == LVW'(1) ? LOSE : LOAD;
        end else if (goal_reached) begin
          if (level == LW'(LEVELS-1)) state <= WIN;
          else begin
            level <= level + 1'b1;
            state <= LOAD;
          end
        end else begin
          if (frame_tick) time_left <= time_left - 1'b1;
`ifdef GAME_PAUSE_EN
          if (p_press) state <= PAUSE;
`endif
        end
        WIN, LOSE: if (enter_press) state <= TITLE;
`ifdef GAME_PAUSE_EN
        PAUSE: if (p_press) state <= PLAY;
`endif
        default: state <= TITLE;
      endcase
    end
  end
endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the game: replaces the bare title/map/win/lose status machine with a full round controller. It edge-detects Enter from the 16-bit USB keycode, runs a per-level countdown and play timer on frame ticks, and tracks level and lives. It also consumes goal and hazard pulses from collision logic. It drives the one-hot `status` used by the display mux, plus level, lives and timer values for the HUD and sprite logic.

## Interface
Parameters:
- `LEVELS`, 4, number of levels; must be ≥ 2.
- `LIVES`, 3, lives per game; must be ≥ 1.
- `COUNTDOWN_FRAMES`, 180, pre-play countdown length in frames; must be ≥ 1.
- `PLAY_FRAMES`, 3600, per-attempt time limit in frames; must be ≥ 1.

Ports:
- `Clk` in 1: 50 MHz clock.
- `Reset` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame (vsync).
- `keycode` in 16: two USB key slots, `[15:8]` and `[7:0]`.
- `goal_reached` in 1: one-cycle pulse when the player reaches the exit.
- `hazard_hit` in 1: one-cycle pulse when the player dies.
- `status` out 4: one-hot status, `{Lose, Win, Play, Background}`.
- `play_en` out 1: player movement and physics enabled.
- `load_level` out 1: one-cycle pulse; sprite logic reloads start positions for `level`.
- `paused` out 1: game paused.
- `level` out `$clog2(LEVELS)`: current level, zero-based.
- `lives` out `$clog2(LIVES+1)`: remaining lives.
- `time_left` out `$clog2(PLAY_FRAMES+1)`: frames left in the current attempt.
- `countdown` out `$clog2(COUNTDOWN_FRAMES+1)`: frames left in the countdown.

## Operation
Key events:
- `enter_now` = (`keycode[15:8]`==8'h28) | (`keycode[7:0]`==8'h28).
- `enter_prev` is a register; `enter_press` = `enter_now` & ~`enter_prev`.
- `enter_prev` resets to 1, so an Enter held through reset never starts a game.
- A held key produces exactly one press.

States:
- TITLE, reset state:
  - On `enter_press`: `level`←0, `lives`←LIVES, go to LOAD.
- LOAD, exactly one cycle:
  - `load_level`=1, `time_left`←PLAY_FRAMES, `countdown`←COUNTDOWN_FRAMES, go to COUNTDOWN.
- COUNTDOWN:
  - On `frame_tick`: if `countdown`==1, go to PLAY with `countdown`←0; otherwise `countdown`−1.
  - `goal_reached` and `hazard_hit` are ignored.
- PLAY:
  - `play_en`=1.
  - Priority per cycle: `hazard_hit` > timeout (`frame_tick` & `time_left`==1) > `goal_reached`.
  - Death (hazard or timeout): if `lives`==1, `lives`←0 and go to LOSE; otherwise `lives`−1 and go to LOAD at the same level.
  - Goal: if `level`==LEVELS−1, go to WIN; otherwise `level`+1 and go to LOAD.
  - Otherwise on `frame_tick`: `time_left`−1.
- WIN, LOSE:
  - On `enter_press`: go to TITLE.
  - `level` and `lives` hold their values for the HUD.
- Unreachable state encodings go to TITLE on the next edge.

`status` decode (from the registered state only; no keycode-to-output combinational path):
- TITLE: 0001.
- LOAD, COUNTDOWN, PLAY, PAUSE: 0010.
- WIN: 0100.
- LOSE: 1000.

Counter rules:
- No counter wraps; decrements occur only under the guards above.
- `level` never exceeds LEVELS−1.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values: `status`=0001, `play_en`=0, `load_level`=0, `paused`=0, `level`=0, `lives`=0, `time_left`=0, `countdown`=0. `Reset` mid-round restores these on the next edge, overriding all other events.
- `enter_press` sampled at edge E: state is LOAD after E, `load_level` is high for cycle E→E+1, state is COUNTDOWN after E+1.
- Event pulse sampled at edge E in PLAY: new state and counters are visible after E, so `play_en` drops 1 cycle after the pulse.
- PLAY lasts at most PLAY_FRAMES `frame_tick`s. COUNTDOWN lasts exactly COUNTDOWN_FRAMES ticks.
- Simultaneous events:
  - `hazard_hit` + `goal_reached`: death.
  - `frame_tick` on the last frame + `goal_reached`: death by timeout.
  - Enter held from WIN into TITLE: no restart until Enter is released and pressed again.

## Configuration
- `GAME_PAUSE_EN` defined:
  - Rising edge of key 8'h13 ('P', either slot, same edge-detect scheme, prev resets to 1) in PLAY goes to PAUSE.
  - In PAUSE: `paused`=1, `play_en`=0; `frame_tick`, `goal_reached` and `hazard_hit` are ignored; `time_left` is frozen.
  - A 'P' edge in PAUSE returns to PLAY; Enter is ignored in PAUSE.
- Undefined:
  - No PAUSE state; `paused` is tied to 0; 8'h13 has no effect.

## Test plan
Bench parameters: LEVELS=2, LIVES=2, COUNTDOWN_FRAMES=3, PLAY_FRAMES=5.
- Reset with `keycode`=16'h0028 held → `status` stays 0001; release, then 16'h2800 for 1 cycle → one `load_level` pulse; after 3 ticks `play_en`=1 and `time_left`=5.
- In PLAY level 0: `goal_reached` → `level`=1, `load_level` pulse, COUNTDOWN. Second goal in PLAY → `status`=0100, `level`=1 holds.
- In PLAY: `hazard_hit` and `goal_reached` in the same cycle → `lives` 2→1, `level` unchanged, reload. Second `hazard_hit` → `status`=1000, `lives`=0.
- In PLAY with no events: 5 `frame_tick`s → `time_left` reaches 1 after 4 ticks; the 5th tick causes death and `lives`−1.
- In WIN with Enter held across the transition → stays WIN; release and press → TITLE (0001).
- `GAME_PAUSE_EN`: 'P' edge in PLAY with `time_left`=4, then 3 ticks plus `hazard_hit` → `time_left`=4, `lives` unchanged; 'P' edge → PLAY resumes. `Reset` asserted mid-PAUSE → all outputs at reset values next cycle.
